bp_be_cache_req_arbiter: RTL and testbench

//  Shares the single D$-to-LCE cache-engine request port between two BE requesters: 0 = dcache, 1 = PTW/aux client.

---
 rtl/bp_be_pkg.sv | 12 +
 rtl/bsg_fifo_1r1w_small.sv | 54 +++++
 rtl/bp_be_cache_req_arbiter.sv | 121 ++++++++++++
 tb/tb_bp_be_cache_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared BE types for the cache-request arbiter.
// Arbiter phase encoding and owner-id width.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_meta  = 1'b1
    } bp_be_cache_arb_state_e;

    localparam int owner_id_width_gp = 1;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO, one read port, one write port.
// Push and pop may coincide at any occupancy, including full.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rd_ptr_r;
    logic [ptr_w-1:0]   wr_ptr_r;
    logic [cnt_w-1:0]   count_r;
    logic               push;
    logic               pop;

    assign v_o     = (count_r != '0);
    assign ready_o = (count_r != cnt_w'(els_p));
    assign data_o  = mem[rd_ptr_r];
    assign pop     = yumi_i & v_o;
    // A pop frees the slot, so a full FIFO still takes a same-cycle push
    assign push    = v_i & (ready_o | pop);

    function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= bump(wr_ptr_r);
            if (pop)  rd_ptr_r <= bump(rd_ptr_r);
            count_r <= count_r + cnt_w'(push) - cnt_w'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bp_be_cache_req_arbiter.sv
// Shares the LCE cache-request port between dcache (0) and PTW (1).
// Round-robin grant; in-order owner FIFO routes responses back.
module bp_be_cache_req_arbiter
    import bp_be_pkg::*;
#(
    parameter int req_width_p  = 8,
    parameter int meta_width_p = 4,
    parameter int owner_els_p  = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [1:0][req_width_p-1:0]  req_i,
    input  logic [1:0]                   req_v_i,
    output logic [1:0]                   req_yumi_o,
    input  logic [1:0][meta_width_p-1:0] meta_i,
    input  logic [1:0]                   meta_v_i,
    output logic [1:0]                   req_busy_o,
    output logic [1:0]                   critical_tag_o,
    output logic [1:0]                   critical_data_o,
    output logic [1:0]                   complete_o,
    output logic [req_width_p-1:0]       cache_req_o,
    output logic                         cache_req_v_o,
    input  logic                         cache_req_yumi_i,
    input  logic                         cache_req_busy_i,
    output logic [meta_width_p-1:0]      cache_req_metadata_o,
    output logic                         cache_req_metadata_v_o,
    input  logic                         cache_req_critical_tag_i,
    input  logic                         cache_req_critical_data_i,
    input  logic                         cache_req_complete_i,
    input  logic                         cache_req_credits_full_i
);

    bp_be_cache_arb_state_e state_r;

    logic                         rr_r;
    logic [owner_id_width_gp-1:0] owner_r;
    logic [owner_id_width_gp-1:0] head;
    logic                         fifo_ready;
    logic                         fifo_v;
    logic                         fifo_full;
    logic                         winner;
    logic                         grant_window;
    logic                         grant;
    logic                         busy_any;
    logic                         resp_ok;
    logic                         pop;

    assign fifo_full = ~fifo_ready;

    assign grant_window = ~reset_i
                        & (state_r == e_ready)
                        & ~cache_req_busy_i
                        & ~cache_req_credits_full_i
                        & ~fifo_full;

    // rr_r names the requester that currently holds priority
    assign winner        = req_v_i[rr_r] ? rr_r : ~rr_r;
    assign cache_req_v_o = grant_window & (|req_v_i);
    assign cache_req_o   = req_i[winner];
    assign grant         = cache_req_v_o & cache_req_yumi_i;
    assign req_yumi_o    = grant ? (2'b01 << winner) : 2'b00;

    assign cache_req_metadata_o   = meta_i[owner_r];
    assign cache_req_metadata_v_o = ~reset_i
                                  & (state_r == e_meta)
                                  & meta_v_i[owner_r];

    assign busy_any = cache_req_busy_i
                    | cache_req_credits_full_i
                    | fifo_full
                    | (state_r == e_meta);
    assign req_busy_o = {2{busy_any}};

    assign resp_ok = ~reset_i & fifo_v;
    assign pop     = resp_ok & cache_req_complete_i;

    assign critical_tag_o  = (resp_ok & cache_req_critical_tag_i)
                           ? (2'b01 << head) : 2'b00;
    assign critical_data_o = (resp_ok & cache_req_critical_data_i)
                           ? (2'b01 << head) : 2'b00;
    assign complete_o      = pop ? (2'b01 << head) : 2'b00;

    bsg_fifo_1r1w_small #(
        .width_p (owner_id_width_gp),
        .els_p   (owner_els_p)
    ) owner_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (grant),
        .ready_o (fifo_ready),
        .data_i  (winner),
        .v_o     (fifo_v),
        .data_o  (head),
        .yumi_i  (pop)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
            rr_r    <= 1'b0;
            owner_r <= '0;
        end else if (grant) begin
            state_r <= e_meta;
            rr_r    <= ~winner;
            owner_r <= winner;
        end else if (cache_req_metadata_v_o) begin
            state_r <= e_ready;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (fifo_v
                    || !(cache_req_critical_tag_i
                         || cache_req_critical_data_i
                         || cache_req_complete_i))
            else $error("cache_req response with no owner");
        end
    end

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Directed bench for bp_be_cache_req_arbiter.
// A queue-based model is checked against the DUT on every negedge.
module tb_bp_be_cache_req_arbiter;

    localparam int RW  = 8;
    localparam int MW  = 4;
    localparam int ELS = 4;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [1:0][RW-1:0]  req_i;
    logic [1:0]          req_v_i;
    logic [1:0]          req_yumi_o;
    logic [1:0][MW-1:0]  meta_i;
    logic [1:0]          meta_v_i;
    logic [1:0]          req_busy_o;
    logic [1:0]          critical_tag_o;
    logic [1:0]          critical_data_o;
    logic [1:0]          complete_o;
    logic [RW-1:0]       cache_req_o;
    logic                cache_req_v_o;
    logic                cache_req_yumi_i;
    logic                cache_req_busy_i;
    logic [MW-1:0]       cache_req_metadata_o;
    logic                cache_req_metadata_v_o;
    logic                cache_req_critical_tag_i;
    logic                cache_req_critical_data_i;
    logic                cache_req_complete_i;
    logic                cache_req_credits_full_i;
    logic                auto_yumi;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    bit m_q[$];
    bit m_meta;
    bit m_owner;
    bit m_prio;
    int gcyc[$];
    bit gwho[$];

    always #5 clk = ~clk;

    // The LCE model accepts any offered request when auto_yumi is set
    assign cache_req_yumi_i = auto_yumi & cache_req_v_o;

    bp_be_cache_req_arbiter #(
        .req_width_p  (RW),
        .meta_width_p (MW),
        .owner_els_p  (ELS)
    ) dut (
        .clk_i                     (clk),
        .reset_i                   (reset_i),
        .req_i                     (req_i),
        .req_v_i                   (req_v_i),
        .req_yumi_o                (req_yumi_o),
        .meta_i                    (meta_i),
        .meta_v_i                  (meta_v_i),
        .req_busy_o                (req_busy_o),
        .critical_tag_o            (critical_tag_o),
        .critical_data_o           (critical_data_o),
        .complete_o                (complete_o),
        .cache_req_o               (cache_req_o),
        .cache_req_v_o             (cache_req_v_o),
        .cache_req_yumi_i          (cache_req_yumi_i),
        .cache_req_busy_i          (cache_req_busy_i),
        .cache_req_metadata_o      (cache_req_metadata_o),
        .cache_req_metadata_v_o    (cache_req_metadata_v_o),
        .cache_req_critical_tag_i  (cache_req_critical_tag_i),
        .cache_req_critical_data_i (cache_req_critical_data_i),
        .cache_req_complete_i      (cache_req_complete_i),
        .cache_req_credits_full_i  (cache_req_credits_full_i)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    initial begin
        forever begin
            bit         ev;
            bit         w;
            bit         emv;
            bit         hv;
            logic [1:0] ey;
            logic [1:0] eb;
            @(negedge clk);
            cyc++;
            if (reset_i) begin
                chk("rst_v", cache_req_v_o, 0);
                chk("rst_yumi", req_yumi_o, 0);
                chk("rst_mv", cache_req_metadata_v_o, 0);
                chk("rst_tag", critical_tag_o, 0);
                chk("rst_data", critical_data_o, 0);
                chk("rst_cmp", complete_o, 0);
                m_q.delete();
                m_meta = 0;
                m_prio = 0;
                m_owner = 0;
            end else begin
                ev = !m_meta && !cache_req_busy_i
                     && !cache_req_credits_full_i
                     && (m_q.size() < ELS) && (req_v_i != 0);
                w  = req_v_i[m_prio] ? m_prio : !m_prio;
                ey = (ev && cache_req_yumi_i) ? onehot(w) : 2'b00;
                chk("v", cache_req_v_o, ev);
                chk("yumi", req_yumi_o, ey);
                if (ev) chk("req", cache_req_o, req_i[w]);
                eb = (cache_req_busy_i || cache_req_credits_full_i
                      || m_q.size() == ELS || m_meta) ? 2'b11 : 2'b00;
                chk("busy", req_busy_o, eb);
                emv = m_meta && meta_v_i[m_owner];
                chk("mv", cache_req_metadata_v_o, emv);
                if (m_meta) chk("meta", cache_req_metadata_o,
                                meta_i[m_owner]);
                hv = m_q.size() > 0;
                chk("tag", critical_tag_o,
                    (hv && cache_req_critical_tag_i)
                    ? onehot(m_q[0]) : 2'b00);
                chk("data", critical_data_o,
                    (hv && cache_req_critical_data_i)
                    ? onehot(m_q[0]) : 2'b00);
                chk("cmp", complete_o,
                    (hv && cache_req_complete_i)
                    ? onehot(m_q[0]) : 2'b00);
                if (hv && cache_req_complete_i) void'(m_q.pop_front());
                if (ey != 0) begin
                    m_q.push_back(w);
                    m_prio  = !w;
                    m_meta  = 1;
                    m_owner = w;
                    gcyc.push_back(cyc);
                    gwho.push_back(w);
                end else if (emv) begin
                    m_meta = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_i = 1;
        req_i[0] = 8'h11;
        req_i[1] = 8'h22;
        meta_i[0] = 4'h5;
        meta_i[1] = 4'hA;
        req_v_i = 0;
        meta_v_i = 0;
        auto_yumi = 0;
        cache_req_busy_i = 0;
        cache_req_critical_tag_i = 0;
        cache_req_critical_data_i = 0;
        cache_req_complete_i = 0;
        cache_req_credits_full_i = 0;
        step(2);

        reset_i = 0;
        req_v_i = 2'b11;
        meta_v_i = 2'b11;
        auto_yumi = 1;
        #2 chk("first_grant", req_yumi_o, 2'b01);
        step(8);
        #2 chk("full_v", cache_req_v_o, 0);
        chk("full_busy", req_busy_o, 2'b11);
        chk("ngrants", gwho.size(), 4);
        if (gwho.size() >= 4) begin
            chk("order", {gwho[0], gwho[1], gwho[2], gwho[3]}, 4'b0101);
            chk("gap1", gcyc[1] - gcyc[0], 2);
            chk("gap2", gcyc[3] - gcyc[2], 2);
        end

        step(1);
        cache_req_complete_i = 1;
        #2 chk("cmp_first", complete_o, 2'b01);
        chk("cmp_full_v", cache_req_v_o, 0);
        step(1);
        cache_req_complete_i = 0;
        #2 chk("resume_v", cache_req_v_o, 1);
        chk("resume_yumi", req_yumi_o, 2'b01);
        step(1);
        req_v_i = 2'b00;

        step(1);
        cache_req_critical_tag_i = 1;
        #2 chk("tag_r1", critical_tag_o, 2'b10);
        step(1);
        cache_req_critical_tag_i = 0;
        cache_req_complete_i = 1;
        #2 chk("cmp_r1", complete_o, 2'b10);
        step(1);
        cache_req_complete_i = 0;
        cache_req_critical_tag_i = 1;
        #2 chk("tag_r0", critical_tag_o, 2'b01);
        step(1);
        cache_req_critical_tag_i = 0;
        cache_req_complete_i = 1;
        #2 chk("cmp_r0", complete_o, 2'b01);
        step(1);
        cache_req_critical_data_i = 1;
        #2 chk("data_r1", critical_data_o, 2'b10);
        chk("cmp_r1b", complete_o, 2'b10);
        step(1);
        cache_req_critical_data_i = 0;
        #2 chk("cmp_r0b", complete_o, 2'b01);

        step(1);
        cache_req_complete_i = 0;
        req_v_i = 2'b01;
        cache_req_credits_full_i = 1;
        #2 chk("cred_v", cache_req_v_o, 0);
        chk("cred_busy", req_busy_o, 2'b11);
        step(2);
        #2 chk("cred_v2", cache_req_v_o, 0);
        step(1);
        cache_req_credits_full_i = 0;
        meta_v_i = 2'b00;
        #2 chk("cred_free", req_yumi_o, 2'b01);

        step(1);
        req_v_i = 2'b00;
        meta_v_i = 2'b10;
        #2 chk("ign_mv", cache_req_metadata_v_o, 0);
        chk("ign_busy", req_busy_o, 2'b11);
        step(1);
        meta_v_i = 2'b00;
        #2 chk("still_meta", req_busy_o, 2'b11);
        step(1);
        meta_v_i = 2'b01;
        #2 chk("own_mv", cache_req_metadata_v_o, 1);
        chk("own_meta", cache_req_metadata_o, 4'h5);
        step(1);
        meta_v_i = 2'b00;
        #2 chk("idle_busy", req_busy_o, 2'b00);

        auto_yumi = 0;
        req_v_i = 2'b11;
        #2 chk("pri1_req", cache_req_o, 8'h22);
        step(1);
        req_v_i = 2'b01;
        #2 chk("drop_req", cache_req_o, 8'h11);
        step(1);
        auto_yumi = 1;
        req_v_i = 2'b10;
        #2 chk("grant1", req_yumi_o, 2'b10);

        step(1);
        reset_i = 1;
        req_v_i = 2'b00;
        meta_v_i = 2'b00;
        #2 chk("mid_rst_v", cache_req_v_o, 0);
        step(1);
        reset_i = 0;
        req_v_i = 2'b11;
        meta_v_i = 2'b11;
        #2 chk("post_rst", req_yumi_o, 2'b01);
        step(8);
        #2 chk("post_rst_full", cache_req_v_o, 0);

        reset_i = 1;
        req_v_i = 2'b00;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
